// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte shifter: widths, state encoding,
// and the first-bit selection helper.
package spi_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    // Kept as plain constants so the encoding matches the legacy netlists.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCK_LO = 2'd1;
    localparam logic [1:0] ST_SCK_HI = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Bit that goes on the wire first for a given shift order.
    function automatic logic first_bit(input logic [SPI_BYTE_W-1:0] b, input logic msb_first);
        return msb_first ? b[SPI_BYTE_W-1] : b[0];
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter. One SCK half-period per ena_2clk pulse, one byte
// per accepted spi_send. A single shift register carries TX data and, when
// the SPI_MISO_RX_EN macro is defined, collects the received MISO bits.
// Without SPI_MISO_RX_EN, miso is ignored and rx_data/rx_valid are tied low.
module spi_byte_shifter
    import spi_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_2clk,
    input  logic       spi_send,
    input  logic [7:0] data_spi,
    input  logic       spi_ss_n,
    input  logic       miso,
    output logic       busy_spi,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam logic MSB_SEL = (MSB_FIRST != 0);

    logic [1:0]               state;
    logic [SPI_BYTE_W-1:0]    shreg;
    logic [SPI_BYTE_W-1:0]    shreg_adv;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic                     mosi_q;
    logic                     shift_in;

`ifdef SPI_MISO_RX_EN
    logic                  rx_bit;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic                  rx_valid_q;

    assign shift_in = rx_bit;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_miso;

    assign unused_miso = miso;
    assign shift_in    = 1'b0;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

    assign busy_spi = (state != ST_IDLE);
    assign sclk     = (state == ST_SCK_HI);
    assign mosi     = mosi_q;

    // Shift register one step ahead; the bit sampled on the rising edge
    // enters at the end opposite to the one being transmitted.
    always_comb begin
        shreg_adv = shreg;
        if (MSB_SEL) begin
            shreg_adv = {shreg[SPI_BYTE_W-2:0], shift_in};
        end else begin
            shreg_adv = {shift_in, shreg[SPI_BYTE_W-1:1]};
        end
    end

    // FSM, shift register, bit counter and MOSI register. mosi is
    // registered so it keeps the last bit while the final shift completes
    // the received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            mosi_q  <= 1'b0;
`ifdef SPI_MISO_RX_EN
            rx_bit     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
`ifdef SPI_MISO_RX_EN
            rx_valid_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (spi_send) begin
                        state   <= ST_SCK_LO;
                        shreg   <= data_spi;
                        bit_cnt <= '0;
                        mosi_q  <= first_bit(data_spi, MSB_SEL);
                    end
                end
                ST_SCK_LO: begin
                    if (spi_ss_n) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else if (ena_2clk) begin
                        state <= ST_SCK_HI;
`ifdef SPI_MISO_RX_EN
                        rx_bit <= miso;
`endif
                    end
                end
                ST_SCK_HI: begin
                    if (spi_ss_n) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else if (ena_2clk) begin
                        shreg <= shreg_adv;
                        if (bit_cnt == SPI_BIT_CNT_W'(SPI_BYTE_W - 1)) begin
                            state   <= ST_DONE;
                            bit_cnt <= '0;
`ifdef SPI_MISO_RX_EN
                            rx_data_q  <= shreg_adv;
                            rx_valid_q <= 1'b1;
`endif
                        end else begin
                            state   <= ST_SCK_LO;
                            bit_cnt <= bit_cnt + 1'b1;
                            mosi_q  <= first_bit(shreg_adv, MSB_SEL);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Self-checking bench for spi_byte_shifter. Two instances (MSB-first and
// LSB-first) share all inputs; each has MISO looped back from its MOSI.
// Receive checks follow the SPI_MISO_RX_EN macro.
module tb_spi_byte_shifter;

`ifdef SPI_MISO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spi_send;
    logic [7:0] data_spi;
    logic       spi_ss_n;
    logic       busy     [2];
    logic       sclk     [2];
    logic       mosi     [2];
    logic       miso     [2];
    logic [7:0] rx_data  [2];
    logic       rx_valid [2];

    int tests = 0;
    int fails = 0;
    int ena_div = 12;
    int ena_cnt = 0;

    logic [7:0] exp_rx [2];

    // Observation results of the last byte.
    int         ob_rises [2];
    logic [7:0] ob_seq   [2];
    int         ob_rxv   [2];
    logic [7:0] ob_rx    [2];
    int         ob_rxv_c;
    int         ob_pulses;
    int         ob_c16;
    int         ob_stop;
    int         ob_fall;
    bit         ob_done;

    always #5 clk = ~clk;

    assign miso[0] = mosi[0];
    assign miso[1] = mosi[1];

    spi_byte_shifter #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .ena_2clk(ena), .spi_send(spi_send), .data_spi(data_spi),
        .spi_ss_n(spi_ss_n), .miso(miso[0]), .busy_spi(busy[0]), .sclk(sclk[0]),
        .mosi(mosi[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0])
    );

    spi_byte_shifter #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .ena_2clk(ena), .spi_send(spi_send), .data_spi(data_spi),
        .spi_ss_n(spi_ss_n), .miso(miso[1]), .busy_spi(busy[1]), .sclk(sclk[1]),
        .mosi(mosi[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1])
    );

    // ena_2clk pulse generator: one pulse every ena_div cycles, driven 1 unit after posedge.
    initial begin
        ena = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ena_cnt = ena_cnt + 1;
            if (ena_cnt >= ena_div) ena_cnt = 0;
            ena = (ena_cnt == 0);
        end
    end

    // Wire order of a byte: bit 7 of the result is the first bit on MOSI.
    function automatic logic [7:0] tx_order(input logic [7:0] b, input bit msb_first);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = msb_first ? b[7-i] : b[i];
        return r;
    endfunction

    // Caller is at +2 in an IDLE cycle; returns at +2 of the cycle after acceptance.
    task automatic drive_send(input logic [7:0] d, input bit hold);
        spi_send = 1'b1;
        data_spi = d;
        @(posedge clk); #2;
        if (!hold) spi_send = 1'b0;
    endtask

    // Follow a byte until busy drops. stop_kind 1 raises spi_ss_n, 2 pulses rst,
    // on the cycle of sclk rise number stop_rise.
    task automatic observe(input int stop_kind, input int stop_rise);
        logic prev [2];
        bit stopped;
        stopped = 1'b0;
        ob_done = 1'b0; ob_pulses = 0; ob_c16 = -1; ob_stop = -1; ob_fall = -1; ob_rxv_c = -1;
        for (int d = 0; d < 2; d++) begin
            ob_rises[d] = 0; ob_seq[d] = '0; ob_rxv[d] = 0; ob_rx[d] = '0; prev[d] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            if (stopped) begin
                spi_ss_n = 1'b0;
                rst = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                if (sclk[d] === 1'b1 && prev[d] !== 1'b1) begin
                    ob_rises[d] = ob_rises[d] + 1;
                    ob_seq[d] = {ob_seq[d][6:0], mosi[d]};
                end
                if (rx_valid[d] === 1'b1) begin
                    ob_rxv[d] = ob_rxv[d] + 1;
                    ob_rx[d] = rx_data[d];
                    if (d == 0) ob_rxv_c = c;
                end
                prev[d] = sclk[d];
            end
            if (busy[0] !== 1'b1) begin
                ob_done = 1'b1;
                ob_fall = c;
                break;
            end
            if (ena) begin
                ob_pulses = ob_pulses + 1;
                if (ob_pulses == 16) ob_c16 = c;
            end
            if (stop_kind != 0 && !stopped && ob_rises[0] == stop_rise && sclk[0] === 1'b1) begin
                if (stop_kind == 1) spi_ss_n = 1'b1;
                else rst = 1'b1;
                stopped = 1'b1;
                ob_stop = c;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_send = 1'b0; spi_ss_n = 1'b0; data_spi = '0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        for (int d = 0; d < 2; d++) begin
            tests++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy[d]); end
            tests++; if (sclk[d] !== 1'b0) begin fails++; $display("FAIL reset_sclk dut%0d got %b want 0", d, sclk[d]); end
            tests++; if (mosi[d] !== 1'b0) begin fails++; $display("FAIL reset_mosi dut%0d got %b want 0", d, mosi[d]); end
            tests++; if (rx_data[d] !== 8'h00) begin fails++; $display("FAIL reset_rx_data dut%0d got %h want 00", d, rx_data[d]); end
            tests++; if (rx_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_rx_valid dut%0d got %b want 0", d, rx_valid[d]); end
            exp_rx[d] = 8'h00;
        end
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_basic_a5();
        ena_div = 12;
        drive_send(8'hA5, 1'b0);
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL a5_busy_start got %b want 1", busy[0]); end
        observe(0, 0);
        tests++; if (!ob_done) begin fails++; $display("FAIL a5_timeout got busy %b want 0", busy[0]); end
        tests++; if (ob_fall - ob_c16 != 2) begin fails++; $display("FAIL a5_end_timing got %0d want 2 cycles after pulse 16", ob_fall - ob_c16); end
        for (int d = 0; d < 2; d++) begin
            tests++; if (ob_rises[d] != 8) begin fails++; $display("FAIL a5_rises dut%0d got %0d want 8", d, ob_rises[d]); end
            tests++; if (ob_seq[d] !== tx_order(8'hA5, d == 0)) begin fails++; $display("FAIL a5_mosi dut%0d got %h want %h", d, ob_seq[d], tx_order(8'hA5, d == 0)); end
            if (RX_EN) begin
                tests++; if (ob_rxv[d] != 1 || ob_rx[d] !== 8'hA5) begin fails++; $display("FAIL a5_rx dut%0d got %0d pulses data %h want 1 pulse data a5", d, ob_rxv[d], ob_rx[d]); end
                exp_rx[d] = 8'hA5;
            end else begin
                tests++; if (ob_rxv[d] != 0 || rx_data[d] !== 8'h00) begin fails++; $display("FAIL a5_rx_off dut%0d got %0d pulses data %h want 0 pulses data 00", d, ob_rxv[d], rx_data[d]); end
            end
        end
        if (RX_EN) begin
            tests++; if (ob_rxv_c != ob_c16 + 1) begin fails++; $display("FAIL a5_rx_valid_cycle got %0d want %0d", ob_rxv_c, ob_c16 + 1); end
        end
    endtask

    task automatic test_idle_hold();
        // Last bit of 0xA5 stays on MOSI; ena pulses must not start anything.
        ena_div = 3;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            tests++; if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || sclk[0] !== 1'b0 || sclk[1] !== 1'b0)
                begin fails++; $display("FAIL idle_quiet got busy %b%b sclk %b%b want 00 00", busy[0], busy[1], sclk[0], sclk[1]); end
            tests++; if (mosi[0] !== 1'b1 || mosi[1] !== 1'b1) begin fails++; $display("FAIL idle_mosi_hold got %b%b want 11", mosi[0], mosi[1]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] d8;
        for (int n = 0; n < 8; n++) begin
            d8 = 8'($urandom);
            ena_div = int'($urandom_range(3, 12));
            repeat (int'($urandom_range(1, 4))) begin @(posedge clk); #2; end
            drive_send(d8, 1'b0);
            tests++; if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin fails++; $display("FAIL rand_busy_start n%0d got %b%b want 11", n, busy[0], busy[1]); end
            observe(0, 0);
            tests++; if (!ob_done || ob_fall - ob_c16 != 2) begin fails++; $display("FAIL rand_end_timing n%0d got done %b gap %0d want done 1 gap 2", n, ob_done, ob_fall - ob_c16); end
            for (int d = 0; d < 2; d++) begin
                tests++; if (ob_rises[d] != 8 || ob_seq[d] !== tx_order(d8, d == 0))
                    begin fails++; $display("FAIL rand_mosi n%0d dut%0d got %0d rises %h want 8 rises %h", n, d, ob_rises[d], ob_seq[d], tx_order(d8, d == 0)); end
                if (RX_EN) begin
                    tests++; if (ob_rxv[d] != 1 || ob_rx[d] !== d8) begin fails++; $display("FAIL rand_rx n%0d dut%0d got %0d pulses %h want 1 pulse %h", n, d, ob_rxv[d], ob_rx[d], d8); end
                    exp_rx[d] = d8;
                end else begin
                    tests++; if (ob_rxv[d] != 0 || rx_data[d] !== 8'h00) begin fails++; $display("FAIL rand_rx_off n%0d dut%0d got %0d pulses %h want 0 pulses 00", n, d, ob_rxv[d], rx_data[d]); end
                end
            end
        end
    endtask

    task automatic test_same_cycle_ena();
        bit found;
        found = 1'b0;
        ena_div = 5;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (ena) begin found = 1'b1; break; end
        end
        tests++; if (!found) begin fails++; $display("FAIL samecyc_no_ena got none want pulse within 20 cycles"); end
        drive_send(8'h5A, 1'b0);
        observe(0, 0);
        tests++; if (!ob_done || ob_fall - ob_c16 != 2) begin fails++; $display("FAIL samecyc_timing got done %b gap %0d want done 1 gap 2", ob_done, ob_fall - ob_c16); end
        for (int d = 0; d < 2; d++) begin
            tests++; if (ob_rises[d] != 8 || ob_seq[d] !== tx_order(8'h5A, d == 0))
                begin fails++; $display("FAIL samecyc_mosi dut%0d got %0d rises %h want 8 rises %h", d, ob_rises[d], ob_seq[d], tx_order(8'h5A, d == 0)); end
            if (RX_EN) exp_rx[d] = 8'h5A;
        end
    endtask

    task automatic test_back_to_back();
        ena_div = 4;
        drive_send(8'h12, 1'b1);
        data_spi = 8'hFF;
        observe(0, 0);
        for (int d = 0; d < 2; d++) begin
            tests++; if (ob_rises[d] != 8 || ob_seq[d] !== tx_order(8'h12, d == 0))
                begin fails++; $display("FAIL b2b_first dut%0d got %0d rises %h want 8 rises %h", d, ob_rises[d], ob_seq[d], tx_order(8'h12, d == 0)); end
        end
        @(posedge clk); #2;
        spi_send = 1'b0;
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL b2b_restart got busy %b want 1", busy[0]); end
        observe(0, 0);
        for (int d = 0; d < 2; d++) begin
            tests++; if (ob_rises[d] != 8 || ob_seq[d] !== 8'hFF) begin fails++; $display("FAIL b2b_second dut%0d got %0d rises %h want 8 rises ff", d, ob_rises[d], ob_seq[d]); end
            if (RX_EN) exp_rx[d] = 8'hFF;
        end
    endtask

    task automatic test_abort();
        ena_div = 6;
        @(posedge clk); #2;
        drive_send(8'($urandom), 1'b0);
        observe(1, 3);
        tests++; if (!ob_done || ob_fall != ob_stop + 1) begin fails++; $display("FAIL abort_busy got done %b gap %0d want done 1 gap 1", ob_done, ob_fall - ob_stop); end
        for (int d = 0; d < 2; d++) begin
            tests++; if (sclk[d] !== 1'b0 || ob_rises[d] != 3) begin fails++; $display("FAIL abort_sclk dut%0d got sclk %b rises %0d want 0 and 3", d, sclk[d], ob_rises[d]); end
            tests++; if (ob_rxv[d] != 0 || rx_data[d] !== exp_rx[d]) begin fails++; $display("FAIL abort_rx dut%0d got %0d pulses %h want 0 pulses %h", d, ob_rxv[d], rx_data[d], exp_rx[d]); end
        end
        repeat (3) begin @(posedge clk); #2; end
        tests++; if (busy[0] !== 1'b0 || rx_valid[0] !== 1'b0) begin fails++; $display("FAIL abort_settle got busy %b rx_valid %b want 0 0", busy[0], rx_valid[0]); end
    endtask

    task automatic test_reset_mid();
        ena_div = 4;
        @(posedge clk); #2;
        drive_send(8'($urandom), 1'b0);
        observe(2, 5);
        tests++; if (!ob_done || ob_fall != ob_stop + 1) begin fails++; $display("FAIL rstmid_busy got done %b gap %0d want done 1 gap 1", ob_done, ob_fall - ob_stop); end
        for (int d = 0; d < 2; d++) begin
            tests++; if (sclk[d] !== 1'b0 || mosi[d] !== 1'b0 || rx_valid[d] !== 1'b0 || rx_data[d] !== 8'h00 || ob_rxv[d] != 0)
                begin fails++; $display("FAIL rstmid_outputs dut%0d got sclk %b mosi %b rxv %b rx %h want 0 0 0 00", d, sclk[d], mosi[d], rx_valid[d], rx_data[d]); end
            exp_rx[d] = 8'h00;
        end
        @(posedge clk); #2;
        drive_send(8'h81, 1'b0);
        observe(0, 0);
        tests++; if (!ob_done || ob_fall - ob_c16 != 2) begin fails++; $display("FAIL rstmid_next_timing got done %b gap %0d want done 1 gap 2", ob_done, ob_fall - ob_c16); end
        for (int d = 0; d < 2; d++) begin
            tests++; if (ob_rises[d] != 8 || ob_seq[d] !== tx_order(8'h81, d == 0))
                begin fails++; $display("FAIL rstmid_next_mosi dut%0d got %0d rises %h want 8 rises %h", d, ob_rises[d], ob_seq[d], tx_order(8'h81, d == 0)); end
            tests++; if (rx_data[d] !== (RX_EN ? 8'h81 : 8'h00)) begin fails++; $display("FAIL rstmid_next_rx dut%0d got %h want %h", d, rx_data[d], RX_EN ? 8'h81 : 8'h00); end
        end
    endtask

    task automatic test_lsb_first_01();
        ena_div = 3;
        @(posedge clk); #2;
        drive_send(8'h01, 1'b0);
        tests++; if (mosi[1] !== 1'b1) begin fails++; $display("FAIL lsb01_first_bit got %b want 1", mosi[1]); end
        observe(0, 0);
        tests++; if (ob_rises[1] != 8 || ob_seq[1] !== 8'h80) begin fails++; $display("FAIL lsb01_pattern got %0d rises %h want 8 rises 80", ob_rises[1], ob_seq[1]); end
        tests++; if (ob_seq[0] !== 8'h01) begin fails++; $display("FAIL msb01_pattern got %h want 01", ob_seq[0]); end
    endtask

    initial begin
        rst = 1'b1; spi_send = 1'b0; spi_ss_n = 1'b0; data_spi = '0;
        test_reset();
        test_basic_a5();
        test_idle_hold();
        test_random();
        test_same_cycle_ena();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_lsb_first_01();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
